ka750_mic_mem_ctl: RTL and testbench
====================================

// Module: ka750_mic_mem_ctl
// PURPOSE
//  Memory interface control (MIC) responder for the DPM datapath. Accepts DPM memory
//  requests (address/data off WBUS, size from d_size_h), runs cycles on the memory port
//  and holds mic_mem_stall_h high until done. Returns read data on the active-low MBUS.
//  Unaligned references may be split into two longword cycles.
// PARAMETERS
//  TIMEOUT  255  b_clk_l cycles a memory strobe may wait for mem_rdy_h before abort
// PORTS
//  b_clk_l       in   1   B clock; all state changes on its rising edge
//  reset_h       in   1   asynchronous reset, active high
//  mem_req_h     in   1   DPM memory request; sampled only while stall low
//  mem_write_h   in   1   1 = write, 0 = read (qualifies mem_req_h)
//  d_size_h      in   3   000 byte, 001 word, 010 long; others reserved
//  va_h          in   32  byte address (WBUS)
//  wbus_h        in   32  write data, right-justified
//  mic_mem_stall_h out 1  DPM stall (gates M/D/QD clock enables)
//  mbus_l_out    out  32  read data, active low; 32'hFFFFFFFF when released
//  mem_addr_h    out  30  longword address
//  mem_rd_h      out  1   read strobe
//  mem_wr_h      out  1   write strobe
//  mem_mask_h    out  4   byte-lane enables
//  mem_wdata_h   out  32  lane-aligned write data
//  mem_rdy_h     in   1   cycle complete
//  mem_err_h     in   1   cycle error, valid with mem_rdy_h
//  mem_rdata_h   in   32  read data, valid with mem_rdy_h
//  err_clr_h     in   1   clears mic_err_h
//  mic_err_h     out  1   sticky error flag
// BEHAVIOUR
//  - Reset (any time, incl. mid-cycle): state IDLE, stall 0, strobes 0, mask 0, addr 0,
//    wdata 0, mbus_l_out all ones, mic_err_h 0, timeout counter 0. Memory cycle abandoned.
//  - States IDLE -> CYC1 -> [CYC2] -> DONE -> IDLE. Stall = registered (state != IDLE).
//  - IDLE: mem_req_h=1 at edge: latch op/size/va; off=va[1:0]; clear read-valid; -> CYC1.
//    Reserved size: set mic_err_h, no memory cycle, -> DONE. Requests while stalled ignored.
//  - CYC1: addr=va[31:2]; strobe per op; wdata = wbus_h rotated left by 8*off;
//    mask = size lanes (1/3/F) shifted left by off, truncated to 4 bits.
//  - CYC2 (unaligned only): addr=va[31:2]+1, wraps 3FFFFFFF->0; same rotated wdata;
//    mask = lanes shifted out of CYC1.
//  - Strobes held until an edge samples mem_rdy_h=1, drop next cycle; earliest completion
//    one edge after strobe asserts. Read lanes captured from mem_rdata_h per mask.
//  - mem_err_h=1 with mem_rdy_h, or counter reaching TIMEOUT: set mic_err_h, skip CYC2,
//    -> DONE, read data not valid. Counter resets at each strobe assertion.
//  - DONE: read ok -> merged lanes rotated right by 8*off, zero-extended to size, held;
//    mbus_l_out = ~data from DONE until next accepted request. -> IDLE (stall drops).
//  - Aligned read, rdy at first opportunity: stall high exactly 3 cycles (CYC1,CYC1,DONE).
//  - err_clr_h and an error set in same cycle: set wins.
// CONFIGURATION
//  MIC_UNALIGNED_EN defined: word with off=3 and long with off!=0 use CYC1+CYC2.
//  Not defined: such references set mic_err_h, issue no memory cycle, go straight to
//  DONE; mbus_l_out stays all ones. Aligned behaviour identical in both builds.
// TESTING
//  - Reset mid-CYC1 with mem_rd_h=1 -> next sample stall 0, mem_rd_h 0, mbus_l_out FFFFFFFF.
//  - Aligned long read va=00001000, rdata=12345678, rdy after 2 cycles -> mem_addr_h=400,
//    mask F, mbus_l_out=EDCBA987, stall 4 cycles.
//  - Byte write va=00000003 wbus=000000AB -> mask 8, mem_wdata_h=AB000000, one cycle.
//  - Long read va=00000002 (UNALIGNED_EN): cycle1 addr 0 mask C data 5678xxxx,
//    cycle2 addr 1 mask 3 data xxxx1234 -> mbus_l_out=EDCBA987; without macro -> mic_err_h=1.
//  - Read with mem_rdy_h never asserted, TIMEOUT=8 -> abort after 8 cycles, mic_err_h=1,
//    stall drops; err_clr_h=1 -> mic_err_h=0.
//  - d_size_h=111 request -> no strobe, mic_err_h=1, stall high 1 cycle.

Source files
------------

// File: rtl/ka750_mic_mem_ctl.sv
// MIC memory responder: runs one or two longword memory cycles per DPM request, stalls DPM until done.
// Build option: define MIC_UNALIGNED_EN to split unaligned references into two cycles (else they error).
module ka750_mic_mem_ctl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        b_clk_l,
  input  logic        reset_h,
  input  logic        mem_req_h,
  input  logic        mem_write_h,
  input  logic [2:0]  d_size_h,
  input  logic [31:0] va_h,
  input  logic [31:0] wbus_h,
  output logic        mic_mem_stall_h,
  output logic [31:0] mbus_l_out,
  output logic [29:0] mem_addr_h,
  output logic        mem_rd_h,
  output logic        mem_wr_h,
  output logic [3:0]  mem_mask_h,
  output logic [31:0] mem_wdata_h,
  input  logic        mem_rdy_h,
  input  logic        mem_err_h,
  input  logic [31:0] mem_rdata_h,
  input  logic        err_clr_h,
  output logic        mic_err_h
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CYC1 = 2'd1;
  localparam logic [1:0] S_CYC2 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  // Lane enables for the reference, spread over two longwords (upper nibble = second cycle).
  function automatic logic [7:0] lane_map(input logic [2:0] sz, input logic [1:0] o);
    logic [7:0] l;
    case (sz)
      3'd0:    l = 8'h01;
      3'd1:    l = 8'h03;
      default: l = 8'h0F;
    endcase
    return l << o;
  endfunction

  logic [1:0]    state_q, state_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   va_q, va_d;
  logic [31:0]   wbus_q, wbus_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [29:0]   addr_q, addr_d;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   rdata_q, rdata_d;
  logic          rd_vld_q, rd_vld_d;
  logic          err_q, err_d, err_set;

  logic [7:0]  req_map, cur_map;
  logic        reserved, unaligned_block;
  logic [63:0] wrot_w, rrot_w;
  logic [31:0] rd_ext;

  assign req_map  = lane_map(d_size_h, va_h[1:0]);
  assign cur_map  = lane_map(size_q, va_q[1:0]);
  assign reserved = (d_size_h > 3'd2);
  assign cnt_inc  = cnt_q + 1'b1;
  assign wrot_w   = {wbus_q, wbus_q} << {va_q[1:0], 3'b000};
  assign rrot_w   = {rdata_q, rdata_q} >> {va_q[1:0], 3'b000};

`ifdef MIC_UNALIGNED_EN
  assign unaligned_block = 1'b0;
`else
  assign unaligned_block = |req_map[7:4];
`endif

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    va_d     = va_q;
    wbus_d   = wbus_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rd_vld_d = rd_vld_q;
    err_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req_h) begin
          write_d  = mem_write_h;
          size_d   = d_size_h;
          va_d     = va_h;
          wbus_d   = wbus_h;
          rd_vld_d = 1'b0;
          if (reserved || unaligned_block) begin
            err_set = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CYC1;
          end
        end
      end
      S_CYC1, S_CYC2: begin
        if (!rd_q && !wr_q) begin
          rd_d    = !write_q;
          wr_d    = write_q;
          addr_d  = (state_q == S_CYC2) ? va_q[31:2] + 30'd1 : va_q[31:2];
          mask_d  = (state_q == S_CYC2) ? cur_map[7:4] : cur_map[3:0];
          wdata_d = wrot_w[63:32];
          cnt_d   = '0;
        end else if (mem_rdy_h) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (mem_err_h) begin
            err_set = 1'b1;
            state_d = S_DONE;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (mask_q[i]) rdata_d[8*i +: 8] = mem_rdata_h[8*i +: 8];
            end
            if (state_q == S_CYC1 && (|cur_map[7:4])) begin
              state_d = S_CYC2;
            end else begin
              state_d  = S_DONE;
              rd_vld_d = !write_q;
            end
          end
        end else if (cnt_inc == TMO) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          cnt_d   = '0;
          err_set = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new error outranks a simultaneous clear.
    err_d = err_set ? 1'b1 : (err_clr_h ? 1'b0 : err_q);
  end

  always_ff @(posedge b_clk_l or posedge reset_h) begin
    if (reset_h) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
      va_q     <= 32'd0;
      wbus_q   <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 30'd0;
      mask_q   <= 4'd0;
      wdata_q  <= 32'd0;
      cnt_q    <= '0;
      rdata_q  <= 32'd0;
      rd_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      va_q     <= va_d;
      wbus_q   <= wbus_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rd_vld_q <= rd_vld_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    case (size_q)
      3'd0:    rd_ext = {24'd0, rrot_w[7:0]};
      3'd1:    rd_ext = {16'd0, rrot_w[15:0]};
      default: rd_ext = rrot_w[31:0];
    endcase
  end

  assign mic_mem_stall_h = (state_q != S_IDLE);
  assign mbus_l_out      = rd_vld_q ? ~rd_ext : 32'hFFFF_FFFF;
  assign mem_addr_h      = addr_q;
  assign mem_rd_h        = rd_q;
  assign mem_wr_h        = wr_q;
  assign mem_mask_h      = mask_q;
  assign mem_wdata_h     = wdata_q;
  assign mic_err_h       = err_q;

endmodule

// File: tb/tb_ka750_mic_mem_ctl.sv
// Scoreboard bench for ka750_mic_mem_ctl: expected strobes and completions are queued by stimulus, checked by a monitor.
module tb_ka750_mic_mem_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_h, mem_write_h, err_clr_h;
  logic [2:0]  d_size_h;
  logic [31:0] va_h, wbus_h;
  logic        mic_mem_stall_h, mem_rd_h, mem_wr_h, mic_err_h;
  logic [31:0] mbus_l_out, mem_wdata_h, mem_rdata_h;
  logic [29:0] mem_addr_h;
  logic [3:0]  mem_mask_h;
  logic        mem_rdy_h, mem_err_h;

  always #5 clk = ~clk;

  ka750_mic_mem_ctl #(.TIMEOUT(8)) dut (
    .b_clk_l(clk), .reset_h(rst),
    .mem_req_h(mem_req_h), .mem_write_h(mem_write_h), .d_size_h(d_size_h),
    .va_h(va_h), .wbus_h(wbus_h),
    .mic_mem_stall_h(mic_mem_stall_h), .mbus_l_out(mbus_l_out),
    .mem_addr_h(mem_addr_h), .mem_rd_h(mem_rd_h), .mem_wr_h(mem_wr_h),
    .mem_mask_h(mem_mask_h), .mem_wdata_h(mem_wdata_h),
    .mem_rdy_h(mem_rdy_h), .mem_err_h(mem_err_h), .mem_rdata_h(mem_rdata_h),
    .err_clr_h(err_clr_h), .mic_err_h(mic_err_h)
  );

  typedef struct packed {
    logic [1:0]  op;     // {rd, wr}
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } strb_t;

  typedef struct packed {
    logic [31:0] mbus;
    logic        err;
    logic [7:0]  cyc;
  } cmp_t;

  strb_t sq[$];
  cmp_t  cq[$];
  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [int];
  int   rlat = 1;
  logic rerr = 1'b0;
  int   rcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: rdy is sampled high on the rlat-th edge after the strobe rises (0 = never).
  always @(negedge clk) begin
    if (rst || !(mem_rd_h || mem_wr_h)) begin
      rcnt = 0;
      mem_rdy_h = 1'b0;
    end else begin
      rcnt++;
      mem_rdy_h = (rlat != 0) && (rcnt == rlat);
    end
    mem_err_h   = mem_rdy_h & rerr;
    mem_rdata_h = mem.exists(int'(mem_addr_h)) ? mem[int'(mem_addr_h)] : 32'hDEAD_BEEF;
  end

  logic prev_stb = 1'b0;
  int   scnt = 0;
  always @(posedge clk) begin
    strb_t es;
    cmp_t  ec;
    #1;
    if ((mem_rd_h || mem_wr_h) && !prev_stb) begin
      if (sq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_strobe: got addr %h, required no strobe", mem_addr_h);
      end else begin
        es = sq.pop_front();
        chk("strobe_op", {30'd0, mem_rd_h, mem_wr_h}, {30'd0, es.op});
        chk("strobe_addr", {2'b00, mem_addr_h}, {2'b00, es.addr});
        chk("strobe_mask", {28'd0, mem_mask_h}, {28'd0, es.mask});
        chk("strobe_wdata", mem_wdata_h, es.wdata);
      end
    end
    prev_stb = mem_rd_h || mem_wr_h;
    if (mic_mem_stall_h) begin
      scnt++;
    end else if (scnt != 0) begin
      if (cq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_completion: got %0d stall cycles, required none", scnt);
      end else begin
        ec = cq.pop_front();
        chk("done_mbus", mbus_l_out, ec.mbus);
        chk("done_err", {31'd0, mic_err_h}, {31'd0, ec.err});
        chk("done_stall_cycles", 32'(scnt), {24'd0, ec.cyc});
      end
      scnt = 0;
    end
  end

  task automatic exp_strb(input logic [1:0] op, input logic [29:0] a, input logic [3:0] m, input logic [31:0] wd);
    strb_t s;
    s.op = op; s.addr = a; s.mask = m; s.wdata = wd;
    sq.push_back(s);
  endtask

  task automatic exp_cmp(input logic [31:0] mb, input logic e, input logic [7:0] c);
    cmp_t x;
    x.mbus = mb; x.err = e; x.cyc = c;
    cq.push_back(x);
  endtask

  task automatic req(input logic wr, input logic [2:0] sz, input logic [31:0] va, input logic [31:0] wd,
                     input int lat, input logic er, input logic clr);
    int k;
    @(negedge clk);
    rlat = lat; rerr = er;
    mem_req_h = 1'b1; mem_write_h = wr; d_size_h = sz; va_h = va; wbus_h = wd; err_clr_h = clr;
    @(negedge clk);
    mem_req_h = 1'b0; err_clr_h = 1'b0;
    k = 0;
    while (mic_mem_stall_h && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (mic_mem_stall_h) begin
      n_chk++; n_fail++;
      $display("FAIL stall_release: stall still %b after 40 cycles, required 0", mic_mem_stall_h);
    end
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr_h = 1'b1;
    @(negedge clk); err_clr_h = 1'b0;
    chk("err_clear", {31'd0, mic_err_h}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_req_h = 0; mem_write_h = 0; d_size_h = 0; va_h = 0; wbus_h = 0; err_clr_h = 0;
    mem_rdy_h = 0; mem_err_h = 0; mem_rdata_h = 0;
    mem[32'h400]      = 32'h1234_5678;
    mem[32'h800]      = 32'hCAFE_1234;
    mem[32'hC00]      = 32'h1122_3344;
    mem[32'h0]        = 32'h5678_AAAA;
    mem[32'h1]        = 32'hBBBB_1234;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, mic_mem_stall_h}, 32'd0);
    chk("rst_rd_wr", {30'd0, mem_rd_h, mem_wr_h}, 32'd0);
    chk("rst_mask", {28'd0, mem_mask_h}, 32'd0);
    chk("rst_addr", {2'b00, mem_addr_h}, 32'd0);
    chk("rst_wdata", mem_wdata_h, 32'd0);
    chk("rst_mbus", mbus_l_out, 32'hFFFF_FFFF);
    chk("rst_err", {31'd0, mic_err_h}, 32'd0);
    rst = 1'b0;

    // aligned long reads, rdy after 2 and after 1 cycle
    exp_strb(2'b10, 30'h400, 4'hF, 32'h0); exp_cmp(32'hEDCB_A987, 1'b0, 8'd4);
    req(1'b0, 3'b010, 32'h0000_1000, 32'h0, 2, 1'b0, 1'b0);
    exp_strb(2'b10, 30'h400, 4'hF, 32'h0); exp_cmp(32'hEDCB_A987, 1'b0, 8'd3);
    req(1'b0, 3'b010, 32'h0000_1000, 32'h0, 1, 1'b0, 1'b0);

    // byte write, off 3
    exp_strb(2'b01, 30'h0, 4'h8, 32'hAB00_0000); exp_cmp(32'hFFFF_FFFF, 1'b0, 8'd3);
    req(1'b1, 3'b000, 32'h0000_0003, 32'h0000_00AB, 1, 1'b0, 1'b0);

    // word read off 2, byte read off 1, word write off 1
    exp_strb(2'b10, 30'h800, 4'hC, 32'h0); exp_cmp(32'hFFFF_3501, 1'b0, 8'd3);
    req(1'b0, 3'b001, 32'h0000_2002, 32'h0, 1, 1'b0, 1'b0);
    exp_strb(2'b10, 30'hC00, 4'h2, 32'h0); exp_cmp(32'hFFFF_FFCC, 1'b0, 8'd3);
    req(1'b0, 3'b000, 32'h0000_3001, 32'h0, 1, 1'b0, 1'b0);
    exp_strb(2'b01, 30'h1, 4'h6, 32'h00BE_EF00); exp_cmp(32'hFFFF_FFFF, 1'b0, 8'd3);
    req(1'b1, 3'b001, 32'h0000_0005, 32'h0000_BEEF, 1, 1'b0, 1'b0);

    // reserved size
    exp_cmp(32'hFFFF_FFFF, 1'b1, 8'd1);
    req(1'b0, 3'b111, 32'h0000_1000, 32'h0, 1, 1'b0, 1'b0);
    clear_err();

`ifdef MIC_UNALIGNED_EN
    exp_strb(2'b10, 30'h0, 4'hC, 32'h0); exp_strb(2'b10, 30'h1, 4'h3, 32'h0);
    exp_cmp(32'hEDCB_A987, 1'b0, 8'd5);
    req(1'b0, 3'b010, 32'h0000_0002, 32'h0, 1, 1'b0, 1'b0);
    exp_strb(2'b01, 30'h3FFF_FFFF, 4'h8, 32'h4411_2233); exp_strb(2'b01, 30'h0, 4'h7, 32'h4411_2233);
    exp_cmp(32'hFFFF_FFFF, 1'b0, 8'd5);
    req(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h1122_3344, 1, 1'b0, 1'b0);
`else
    exp_cmp(32'hFFFF_FFFF, 1'b1, 8'd1);
    req(1'b0, 3'b010, 32'h0000_0002, 32'h0, 1, 1'b0, 1'b0);
    clear_err();
    exp_cmp(32'hFFFF_FFFF, 1'b1, 8'd1);
    req(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h1122_3344, 1, 1'b0, 1'b0);
    clear_err();
`endif

    // memory error response
    exp_strb(2'b10, 30'h1000, 4'hF, 32'h0); exp_cmp(32'hFFFF_FFFF, 1'b1, 8'd3);
    req(1'b0, 3'b010, 32'h0000_4000, 32'h0, 1, 1'b1, 1'b0);
    clear_err();

    // timeout: strobe held 8 cycles, then abort
    exp_strb(2'b10, 30'h400, 4'hF, 32'h0); exp_cmp(32'hFFFF_FFFF, 1'b1, 8'd10);
    req(1'b0, 3'b010, 32'h0000_1000, 32'h0, 0, 1'b0, 1'b0);
    clear_err();

    // error set and clear in the same cycle: set wins
    exp_cmp(32'hFFFF_FFFF, 1'b1, 8'd1);
    req(1'b0, 3'b011, 32'h0000_1000, 32'h0, 1, 1'b0, 1'b1);
    clear_err();

    // reset while a read strobe is active
    exp_strb(2'b10, 30'h400, 4'hF, 32'h0); exp_cmp(32'hFFFF_FFFF, 1'b0, 8'd2);
    @(negedge clk);
    rlat = 0; mem_req_h = 1'b1; mem_write_h = 1'b0; d_size_h = 3'b010; va_h = 32'h0000_1000; wbus_h = 0;
    @(negedge clk); mem_req_h = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("midrst_stall", {31'd0, mic_mem_stall_h}, 32'd0);
    chk("midrst_rd", {31'd0, mem_rd_h}, 32'd0);
    chk("midrst_mbus", mbus_l_out, 32'hFFFF_FFFF);
    @(negedge clk); rst = 1'b0;

    exp_strb(2'b10, 30'h400, 4'hF, 32'h0); exp_cmp(32'hEDCB_A987, 1'b0, 8'd3);
    req(1'b0, 3'b010, 32'h0000_1000, 32'h0, 1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("strobe_queue_empty", 32'(sq.size()), 32'd0);
    chk("completion_queue_empty", 32'(cq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
